data_sram_ctrl: RTL and testbench
=================================

# data_sram_ctrl

MEM-stage data-memory access controller: turns one pipeline load/store into a single sram-like bus transaction (req / addr_ok / data_ok), generates byte strobes and aligned write data, extracts and extends load data, and stalls the pipeline until the access completes. Sits between the MEM-stage decode signals and the CPU's data-side sram-like port. It detects misaligned accesses and reports them instead of issuing them.

## Interface
- No parameters; address and data are fixed at 32 bits.
- clk  in  1  system clock.
- rst  in  1  reset; synchronous and active-high.
- mem_valid  in  1  MEM stage holds a valid instruction.
- load_store_mem  in  3  000 none, 001 lb/lbu, 010 lh/lhu, 011 lw, 101 sb, 110 sh, 111 sw; 100 treated as none.
- load_unsigned_mem  in  1  zero-extend the load when set (lbu/lhu); ignored for lw and stores.
- addr_mem  in  32  effective byte address.
- rdata2_mem  in  32  store source register.
- mem_flush  in  1  exception/eret flush of MEM.
- mem_hold  in  1  a downstream stall keeps MEM from advancing.
- data_req  out  1  bus request.
- data_wr  out  1  1 = write.
- data_size  out  2  0 byte, 1 half, 2 word.
- data_addr  out  32  request address (low 2 bits are kept).
- data_wstrb  out  4  byte enables, valid on writes.
- data_wdata  out  32  aligned store data.
- data_addr_ok  in  1  request accepted.
- data_data_ok  in  1  write done or read data valid.
- data_rdata  in  32  read data.
- mem_stall  out  1  freeze IF–MEM.
- load_result  out  32  extended load value.
- exc_adel  out  1  load address error.
- exc_ades  out  1  store address error.
- bad_vaddr  out  32  the faulting address; equals addr_mem.

## Operation
- The block has four states: IDLE, REQ, WAIT, DONE.
- Misalignment:
  - Halfword ops fault when addr[0]=1.
  - lw/sw fault when addr[1:0]≠0.
  - exc_adel/exc_ades = mem_valid & op & misaligned & ~mem_flush, driven combinationally.
  - A faulting access issues no request, and mem_stall is 0 for it.
- IDLE → REQ when mem_valid, the op is not none, the access is aligned and mem_flush=0.
  - On this transition the block registers wr, size, addr, wstrb and wdata.
- Byte strobes, with off = addr[1:0]:
  - sb: 4'b0001<<off.
  - sh: 4'b0011<<off.
  - sw: 4'b1111.
  - Loads drive 0.
- Write data:
  - off=0: rdata2_mem unchanged.
  - off=1: {rdata2[23:0],8'h00}.
  - off=2: {rdata2[15:0],16'h0}.
  - off=3: {rdata2[7:0],24'h0}.
  - sw is never shifted.
- REQ: data_req=1, with all request fields held stable.
  - data_addr_ok & data_data_ok → DONE.
  - data_addr_ok alone → WAIT.
  - Otherwise stay in REQ.
- WAIT: data_req=0. data_data_ok → DONE.
- Load capture happens on the data_ok cycle, loads only:
  - shifted = data_rdata >> (8*off).
  - Byte loads: bit 7 sign-extends, or zero-extend if unsigned.
  - Halfword loads: bit 15 sign-extends, or zero-extend if unsigned.
  - Word loads take the full value.
  - The result is registered into load_result.
- DONE: the result is presented.
  - mem_hold=1: stay in DONE.
  - Otherwise → IDLE. Any new instruction is considered from the next cycle.
- mem_stall = (IDLE & issue condition) | REQ | WAIT. It is 0 in DONE.
- Flush:
  - In IDLE, a flush suppresses the issue.
  - In REQ, the request stays asserted until data_addr_ok, because the sram-like protocol forbids withdrawing it.
  - A flush seen in REQ or WAIT sets a discard flag. The transaction still completes. On data_ok the block goes to IDLE (not DONE), load_result is left unchanged, and the flag clears.
  - mem_stall stays 1 until that data_ok.
  - A flush arriving in DONE → IDLE.
- At most one transaction is outstanding. No new request is issued before the data_ok of the previous one.

## Timing
- Reset (synchronous, rst=1 at a clk edge) puts every output in a known state:
  - State becomes IDLE.
  - data_req=0, data_wr=0, data_size=0, data_addr=0, data_wstrb=0, data_wdata=0, load_result=0.
  - The discard flag is cleared.
  - mem_stall, exc_adel, exc_ades and bad_vaddr are combinational and follow their inputs.
- A reset mid-transaction abandons it; any late data_ok is ignored in IDLE.
- data_req rises one cycle after the issue cycle. The minimum access, with addr_ok and data_ok in the same cycle, costs 2 stall cycles.
- Latency from the issue cycle to load_result valid = 2 + addr_ok wait + data_ok wait cycles.
- data_ok seen in IDLE or DONE is ignored.

## Test plan
- **sw, fast bus.** Stimulus: sw at addr 0x100, rdata2=0x11223344, addr_ok and data_ok both in the first REQ cycle. Required: data_req high for one cycle, wstrb=1111, wdata=0x11223344, mem_stall high for 2 cycles.
- **sb, slow bus.** Stimulus: sb at off=3, rdata2=0x000000AB; addr_ok after 3 cycles, data_ok 2 cycles later. Required: wstrb=1000, wdata=0xAB000000, req held for 4 cycles, stall drops exactly in DONE.
- **Load extension.**
  - lb at off=1 with rdata=0x0000_8000 → load_result=0xFFFFFF80.
  - lbu → 0x00000080.
  - lh at off=2 with rdata=0x7FFF_0000 → 0x00007FFF.
- **Misalignment.**
  - lw at 0x102 → exc_adel=1, bad_vaddr=0x102, data_req never rises, stall=0.
  - sh at 0x101 → exc_ades=1.
- **Flush during REQ.** Stimulus: mem_flush during REQ with addr_ok delayed 2 cycles. Required: req held until addr_ok, load_result unchanged after data_ok, state returns to IDLE, no DONE cycle.
- **Hold and reset.**
  - mem_hold=1 for 3 cycles in DONE: load_result is stable and no new req is issued.
  - rst asserted in WAIT: next cycle all registered outputs are 0, and a subsequent data_ok is ignored.

Source files
------------

// File: rtl/data_sram_ctrl.sv
// data_sram_ctrl: turns one MEM-stage load/store into a single sram-like bus
// transaction, aligns store data, extends load data and stalls MEM until done.
module data_sram_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic [2:0]  load_store_mem,
  input  logic        load_unsigned_mem,
  input  logic [31:0] addr_mem,
  input  logic [31:0] rdata2_mem,
  input  logic        mem_flush,
  input  logic        mem_hold,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        mem_stall,
  output logic [31:0] load_result,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic [31:0] bad_vaddr
);

  // state  | meaning
  // IDLE   | no transaction; an aligned, unflushed access issues from here
  // REQ    | data_req high, waiting for addr_ok
  // WAIT   | address accepted, waiting for data_ok
  // DONE   | load_result presented; held here while mem_hold is set
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic        discard;
  logic        unsigned_q;

  logic        is_store;
  logic        op_valid;
  logic [1:0]  off;
  logic        misaligned;
  logic        access_ok;
  logic        issue;
  logic        in_flight;
  logic        bus_done;
  logic        drop;

  logic [1:0]  size_nxt;
  logic [3:0]  wstrb_nxt;
  logic [31:0] wdata_nxt;
  logic [31:0] shifted;
  logic [31:0] load_ext;

  assign is_store   = load_store_mem[2];
  assign op_valid   = (load_store_mem[1:0] != 2'b00);
  assign off        = addr_mem[1:0];
  assign misaligned = ((load_store_mem[1:0] == 2'b10) && off[0]) ||
                      ((load_store_mem[1:0] == 2'b11) && (off != 2'b00));
  assign access_ok  = mem_valid & op_valid & ~mem_flush;

  assign exc_adel   = access_ok & ~is_store & misaligned;
  assign exc_ades   = access_ok & is_store & misaligned;
  assign bad_vaddr  = addr_mem;

  assign issue      = (state == S_IDLE) & access_ok & ~misaligned;
  assign in_flight  = (state == S_REQ) | (state == S_WAIT);
  assign bus_done   = ((state == S_REQ) & data_addr_ok & data_data_ok) |
                      ((state == S_WAIT) & data_data_ok);
  // A flush on the completing cycle itself must also discard the result.
  assign drop       = discard | mem_flush;

  assign data_req   = (state == S_REQ);
  assign mem_stall  = issue | in_flight;

  always_comb begin
    size_nxt  = 2'd0;
    wstrb_nxt = 4'b0000;
    wdata_nxt = rdata2_mem;
    case (load_store_mem[1:0])
      2'b01: begin
        size_nxt  = 2'd0;
        wstrb_nxt = 4'b0001 << off;
      end
      2'b10: begin
        size_nxt  = 2'd1;
        wstrb_nxt = 4'b0011 << off;
      end
      2'b11: begin
        size_nxt  = 2'd2;
        wstrb_nxt = 4'b1111;
      end
      default: begin
        size_nxt  = 2'd0;
        wstrb_nxt = 4'b0000;
      end
    endcase
    if (!is_store) begin
      wstrb_nxt = 4'b0000;
    end
    if (load_store_mem[1:0] != 2'b11) begin
      case (off)
        2'd1:    wdata_nxt = {rdata2_mem[23:0], 8'h00};
        2'd2:    wdata_nxt = {rdata2_mem[15:0], 16'h0000};
        2'd3:    wdata_nxt = {rdata2_mem[7:0], 24'h000000};
        default: wdata_nxt = rdata2_mem;
      endcase
    end
  end

  assign shifted = data_rdata >> {data_addr[1:0], 3'b000};

  always_comb begin
    case (data_size)
      2'd0: begin
        if (unsigned_q) load_ext = {24'h000000, shifted[7:0]};
        else            load_ext = {{24{shifted[7]}}, shifted[7:0]};
      end
      2'd1: begin
        if (unsigned_q) load_ext = {16'h0000, shifted[15:0]};
        else            load_ext = {{16{shifted[15]}}, shifted[15:0]};
      end
      default: load_ext = shifted;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (issue) state_nxt = S_REQ;
      end
      S_REQ: begin
        if (data_addr_ok && data_data_ok) state_nxt = drop ? S_IDLE : S_DONE;
        else if (data_addr_ok)            state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (data_data_ok) state_nxt = drop ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        if (mem_flush || !mem_hold) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      discard     <= 1'b0;
      unsigned_q  <= 1'b0;
      data_wr     <= 1'b0;
      data_size   <= 2'd0;
      data_addr   <= 32'h0;
      data_wstrb  <= 4'b0000;
      data_wdata  <= 32'h0;
      load_result <= 32'h0;
    end else begin
      state <= state_nxt;
      if (issue) begin
        data_wr    <= is_store;
        data_size  <= size_nxt;
        data_addr  <= addr_mem;
        data_wstrb <= wstrb_nxt;
        data_wdata <= wdata_nxt;
        unsigned_q <= load_unsigned_mem;
      end
      if (bus_done) begin
        discard <= 1'b0;
      end else if (in_flight && mem_flush) begin
        discard <= 1'b1;
      end
      if (bus_done && !drop && !data_wr) begin
        load_result <= load_ext;
      end
    end
  end

endmodule

// File: tb/tb_data_sram_ctrl.sv
// Scoreboard bench for data_sram_ctrl: stimulus pushes expected request and
// completion records; a negedge monitor pops and compares them.
module tb_data_sram_ctrl;

  logic        clk;
  logic        rst;
  logic        mem_valid;
  logic [2:0]  load_store_mem;
  logic        load_unsigned_mem;
  logic [31:0] addr_mem;
  logic [31:0] rdata2_mem;
  logic        mem_flush;
  logic        mem_hold;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_stall;
  logic [31:0] load_result;
  logic        exc_adel;
  logic        exc_ades;
  logic [31:0] bad_vaddr;

  data_sram_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .mem_valid         (mem_valid),
    .load_store_mem    (load_store_mem),
    .load_unsigned_mem (load_unsigned_mem),
    .addr_mem          (addr_mem),
    .rdata2_mem        (rdata2_mem),
    .mem_flush         (mem_flush),
    .mem_hold          (mem_hold),
    .data_req          (data_req),
    .data_wr           (data_wr),
    .data_size         (data_size),
    .data_addr         (data_addr),
    .data_wstrb        (data_wstrb),
    .data_wdata        (data_wdata),
    .data_addr_ok      (data_addr_ok),
    .data_data_ok      (data_data_ok),
    .data_rdata        (data_rdata),
    .mem_stall         (mem_stall),
    .load_result       (load_result),
    .exc_adel          (exc_adel),
    .exc_ades          (exc_ades),
    .bad_vaddr         (bad_vaddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    int          req_cycles;
  } req_t;

  typedef struct {
    logic [31:0] res;
    int          stall_cycles;
    logic        stall_after;
  } done_t;

  req_t  req_q[$];
  done_t done_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor
  int   stall_cnt;
  int   req_cnt;
  logic outstanding;
  logic finish_pending;

  initial begin
    stall_cnt = 0;
    req_cnt = 0;
    outstanding = 1'b0;
    finish_pending = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_cnt = 0;
        req_cnt = 0;
        outstanding = 1'b0;
        finish_pending = 1'b0;
      end else begin
        if (finish_pending) begin
          finish_pending = 1'b0;
          if (done_q.size() == 0) begin
            chk("done_q_nonempty", 32'd0, 32'd1);
          end else begin
            done_t d;
            d = done_q.pop_front();
            chk("load_result", load_result, d.res);
            chk("stall_after_done", {31'd0, mem_stall}, {31'd0, d.stall_after});
            chk("stall_cycles", stall_cnt, d.stall_cycles);
          end
          stall_cnt = 0;
        end
        if (mem_stall) stall_cnt++;
        if (data_req) begin
          req_cnt++;
          if (req_q.size() == 0) chk("unexpected_req", {31'd0, data_req}, 32'd0);
        end
        if (data_req && data_addr_ok && req_q.size() != 0) begin
          req_t r;
          r = req_q.pop_front();
          chk("req_wr", {31'd0, data_wr}, {31'd0, r.wr});
          chk("req_size", {30'd0, data_size}, {30'd0, r.size});
          chk("req_addr", data_addr, r.addr);
          chk("req_wstrb", {28'd0, data_wstrb}, {28'd0, r.wstrb});
          if (r.wr) chk("req_wdata", data_wdata, r.wdata);
          chk("req_cycles", req_cnt, r.req_cycles);
          req_cnt = 0;
          outstanding = 1'b1;
        end
        if (outstanding && data_data_ok) begin
          outstanding = 1'b0;
          finish_pending = 1'b1;
        end
      end
    end
  end

  task automatic access(input logic [2:0] op, input logic uns, input logic [31:0] addr,
                        input logic [31:0] src, input logic [31:0] rdata,
                        input int ao_wait, input int do_wait, input logic flush,
                        input int hold, input logic [3:0] exp_wstrb,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_res);
    req_t  r;
    done_t d;
    @(posedge clk); #1;
    mem_valid = 1'b1; load_store_mem = op; load_unsigned_mem = uns;
    addr_mem = addr; rdata2_mem = src; mem_flush = 1'b0; mem_hold = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
    r.wr = op[2]; r.size = op[1:0] - 2'd1; r.addr = addr; r.wstrb = exp_wstrb;
    r.wdata = exp_wdata; r.req_cycles = ao_wait + 1;
    d.res = exp_res; d.stall_cycles = 2 + ao_wait + do_wait; d.stall_after = flush;
    req_q.push_back(r);
    done_q.push_back(d);
    @(posedge clk); #1;
    if (flush) mem_flush = 1'b1;
    for (int i = 0; i < ao_wait; i++) begin
      @(posedge clk); #1;
      mem_flush = 1'b0;
      if (flush) mem_valid = 1'b0;
    end
    data_addr_ok = 1'b1;
    data_rdata = rdata;
    data_data_ok = (do_wait == 0);
    if (do_wait > 0) begin
      @(posedge clk); #1;
      data_addr_ok = 1'b0; mem_flush = 1'b0;
      for (int i = 0; i < do_wait - 1; i++) begin
        @(posedge clk); #1;
      end
      data_data_ok = 1'b1;
    end
    if (flush) return;
    @(posedge clk); #1;
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
    mem_hold = (hold > 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_result", load_result, exp_res);
      chk("hold_stall", {31'd0, mem_stall}, 32'd0);
      @(posedge clk); #1;
      if (i == hold - 1) mem_hold = 1'b0;
    end
    @(posedge clk); #1;
    mem_valid = 1'b0; load_store_mem = 3'b000;
  endtask

  task automatic misalign(input logic [2:0] op, input logic [31:0] addr,
                          input logic exp_adel, input logic exp_ades);
    @(posedge clk); #1;
    mem_valid = 1'b1; load_store_mem = op; addr_mem = addr; mem_flush = 1'b0;
    @(negedge clk);
    chk("exc_adel", {31'd0, exc_adel}, {31'd0, exp_adel});
    chk("exc_ades", {31'd0, exc_ades}, {31'd0, exp_ades});
    chk("bad_vaddr", bad_vaddr, addr);
    chk("misalign_stall", {31'd0, mem_stall}, 32'd0);
    @(posedge clk); #1;
    mem_flush = 1'b1;
    @(negedge clk);
    chk("flushed_exc", {30'd0, exc_adel, exc_ades}, 32'd0);
    @(posedge clk); #1;
    mem_valid = 1'b0; mem_flush = 1'b0; load_store_mem = 3'b000;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; mem_valid = 1'b0; load_store_mem = 3'b000; load_unsigned_mem = 1'b0;
    addr_mem = 32'h0; rdata2_mem = 32'h0; mem_flush = 1'b0; mem_hold = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_req", {31'd0, data_req}, 32'd0);
    chk("rst_addr", data_addr, 32'h0);
    chk("rst_wstrb", {28'd0, data_wstrb}, 32'd0);
    chk("rst_load_result", load_result, 32'h0);
    chk("rst_stall", {31'd0, mem_stall}, 32'd0);

    // op, uns, addr, src, rdata, ao, do, flush, hold, wstrb, wdata, result
    access(3'b111, 1'b0, 32'h100, 32'h11223344, 32'hFFFFFFFF, 0, 0, 1'b0, 0, 4'b1111, 32'h11223344, 32'h0);
    access(3'b101, 1'b0, 32'h103, 32'h000000AB, 32'hFFFFFFFF, 3, 2, 1'b0, 0, 4'b1000, 32'hAB000000, 32'h0);
    access(3'b001, 1'b0, 32'h201, 32'h0, 32'h00008000, 0, 0, 1'b0, 0, 4'b0000, 32'h0, 32'hFFFFFF80);
    access(3'b001, 1'b1, 32'h201, 32'h0, 32'h00008000, 0, 0, 1'b0, 0, 4'b0000, 32'h0, 32'h00000080);
    access(3'b010, 1'b0, 32'h202, 32'h0, 32'h7FFF0000, 0, 0, 1'b0, 0, 4'b0000, 32'h0, 32'h00007FFF);
    access(3'b010, 1'b1, 32'h200, 32'h0, 32'h1234F00D, 0, 0, 1'b0, 0, 4'b0000, 32'h0, 32'h0000F00D);
    access(3'b010, 1'b0, 32'h200, 32'h0, 32'h1234F00D, 0, 0, 1'b0, 0, 4'b0000, 32'h0, 32'hFFFFF00D);
    access(3'b110, 1'b0, 32'h102, 32'h0000BEEF, 32'h0BADF00D, 0, 0, 1'b0, 0, 4'b1100, 32'hBEEF0000, 32'hFFFFF00D);
    access(3'b011, 1'b0, 32'h104, 32'h0, 32'hCAFEF00D, 1, 1, 1'b0, 0, 4'b0000, 32'h0, 32'hCAFEF00D);
    // flushed load: result must stay, and the next load issues right away
    access(3'b011, 1'b0, 32'h108, 32'h0, 32'h55555555, 2, 1, 1'b1, 0, 4'b0000, 32'h0, 32'hCAFEF00D);
    access(3'b001, 1'b1, 32'h10B, 32'h0, 32'h7F000000, 0, 0, 1'b0, 0, 4'b0000, 32'h0, 32'h0000007F);
    access(3'b011, 1'b0, 32'h300, 32'h0, 32'h89ABCDEF, 0, 0, 1'b0, 3, 4'b0000, 32'h0, 32'h89ABCDEF);

    misalign(3'b011, 32'h102, 1'b1, 1'b0);
    misalign(3'b110, 32'h101, 1'b0, 1'b1);

    // reset while waiting for data_ok
    begin
      req_t r;
      @(posedge clk); #1;
      mem_valid = 1'b1; load_store_mem = 3'b011; addr_mem = 32'h200; rdata2_mem = 32'h12345678;
      r.wr = 1'b0; r.size = 2'd2; r.addr = 32'h200; r.wstrb = 4'b0000; r.wdata = 32'h0; r.req_cycles = 1;
      req_q.push_back(r);
      @(posedge clk); #1;
      data_addr_ok = 1'b1;
      @(posedge clk); #1;
      data_addr_ok = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; mem_valid = 1'b0; load_store_mem = 3'b000;
      @(negedge clk);
      chk("wait_rst_regs", {data_req, data_wr, data_size, data_wstrb}, 32'd0);
      chk("wait_rst_addr", data_addr, 32'h0);
      chk("wait_rst_wdata", data_wdata, 32'h0);
      chk("wait_rst_result", load_result, 32'h0);
      @(posedge clk); #1;
      data_data_ok = 1'b1; data_rdata = 32'hDEADBEEF;
      @(posedge clk); #1;
      data_data_ok = 1'b0;
      @(negedge clk);
      chk("late_ok_result", load_result, 32'h0);
      chk("late_ok_req", {31'd0, data_req}, 32'd0);
      chk("late_ok_stall", {31'd0, mem_stall}, 32'd0);
    end

    access(3'b001, 1'b1, 32'h002, 32'h0, 32'h00FE0000, 0, 0, 1'b0, 0, 4'b0000, 32'h0, 32'h000000FE);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("req_q_drained", req_q.size(), 32'd0);
    chk("done_q_drained", done_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
